// File: rtl/unsigned_divider.sv
// Sequential restoring divider: 12-bit dividend / 4-bit divisor -> 8-bit quotient, 4-bit remainder.
// Counterpart of the 8x4 multiplier; one quotient bit per clock behind a START/DONE handshake.
module unsigned_divider (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [11:0] DIVIDEND,
  input  logic [3:0]  DIVISOR,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  QUOT,
  output logic [3:0]  REM,
  output logic        DIV0,
  output logic        OVF
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      state_q,    state_d;
  logic [7:0]  shift_q,    shift_d;     // low dividend bits out of MSB, quotient bits in at LSB
  logic [3:0]  dvs_q,      dvs_d;
  logic [3:0]  part_q,     part_d;      // partial remainder; always < divisor, so 4 bits suffice
  logic [2:0]  cnt_q,      cnt_d;
  logic [7:0]  quot_q,     quot_d;
  logic [3:0]  rem_q,      rem_d;
  logic        div0_q,     div0_d;
  logic        ovf_q,      ovf_d;

  // One restoring step: trial value is the partial remainder with the next dividend bit appended.
  logic [4:0]  trial;
  logic        q_bit;
  logic [3:0]  step_rem;

  always_comb begin
    trial = {part_q, shift_q[7]};
    q_bit = (trial >= {1'b0, dvs_q});
    // When the subtraction happens the true result is below the divisor, so the low 4 bits are exact.
    step_rem = q_bit ? (trial[3:0] - dvs_q) : trial[3:0];
  end

  // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          shift_d = DIVIDEND[7:0];
          dvs_d   = DIVISOR;
          div0_d  = 1'b0;
          ovf_d   = 1'b0;
          if (DIVISOR == 4'd0) begin
            state_d = S_FIN;
            div0_d  = 1'b1;
            quot_d  = 8'hFF;
            rem_d   = 4'hF;
          end else if (DIVIDEND[11:8] >= DIVISOR) begin
            state_d = S_FIN;
            ovf_d   = 1'b1;
            quot_d  = 8'hFF;
            rem_d   = 4'hF;
          end else begin
            state_d = S_RUN;
            part_d  = DIVIDEND[11:8];
            cnt_d   = 3'd7;
          end
        end
      end

      S_RUN: begin
        part_d  = step_rem;
        shift_d = {shift_q[6:0], q_bit};
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = S_FIN;
          quot_d  = {shift_q[6:0], q_bit};
          rem_d   = step_rem;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      shift_q <= 8'd0;
      dvs_q   <= 4'd0;
      part_q  <= 4'd0;
      cnt_q   <= 3'd0;
      quot_q  <= 8'd0;
      rem_q   <= 4'd0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_FIN);
  assign QUOT = quot_q;
  assign REM  = rem_q;
  assign DIV0 = div0_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_unsigned_divider.sv
// Directed bench for unsigned_divider: latency, handshake, error flags, reset and a checked sweep.
// Outputs are sampled on the falling edge; inputs change on the falling edge or just after rising.
module tb_unsigned_divider;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [11:0] DIVIDEND;
  logic [3:0]  DIVISOR;
  logic        BUSY;
  logic        DONE;
  logic [7:0]  QUOT;
  logic [3:0]  REM;
  logic        DIV0;
  logic        OVF;

  int checks = 0;
  int errors = 0;

  unsigned_divider dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .DIVIDEND (DIVIDEND),
    .DIVISOR  (DIVISOR),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .QUOT     (QUOT),
    .REM      (REM),
    .DIV0     (DIV0),
    .OVF      (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] a;
    logic [3:0]  b;
    logic [7:0]  q;
    logic [3:0]  r;
    logic        div0;
    logic        ovf;
  } vec_t;

  // Issue one operation and wait for DONE; lat is the cycle index (1 = first cycle after
  // the accepting edge) in which DONE was seen, or -1 on timeout.
  task automatic run_op(input logic [11:0] a, input logic [3:0] b,
                        output int lat, output int busy_n);
    @(negedge CLK);
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    @(posedge CLK);
    #1;
    START    = 1'b0;
    DIVIDEND = ~a;
    DIVISOR  = ~b;
    lat      = -1;
    busy_n   = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (BUSY) busy_n++;
      if (DONE) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    START = 1'b0;
    DIVIDEND = 12'h000;
    DIVISOR = 4'h0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({BUSY, DONE, QUOT, REM, DIV0, OVF} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b q=%h r=%h div0=%b ovf=%b want all zero",
               BUSY, DONE, QUOT, REM, DIV0, OVF);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_basic();
    int lat, busy_n;
    run_op(12'h4B0, 4'hA, lat, busy_n);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
    checks++;
    if (busy_n !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", busy_n); end
    checks++;
    if ({QUOT, REM, DIV0, OVF} !== {8'h78, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result got q=%h r=%h div0=%b ovf=%b want q=78 r=0 div0=0 ovf=0",
               QUOT, REM, DIV0, OVF);
    end
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b0 || QUOT !== 8'h78 || REM !== 4'h0) begin
      errors++;
      $display("FAIL basic_pulse_hold got done=%b q=%h r=%h want done=0 q=78 r=0", DONE, QUOT, REM);
    end
  endtask

  task automatic test_table(input string name, input vec_t v[]);
    int lat, busy_n, want_lat;
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, lat, busy_n);
      want_lat = (v[i].div0 || v[i].ovf) ? 1 : 9;
      checks++;
      if ({QUOT, REM, DIV0, OVF} !== {v[i].q, v[i].r, v[i].div0, v[i].ovf} || lat !== want_lat) begin
        errors++;
        $display("FAIL %s[%0d] %h/%h got q=%h r=%h div0=%b ovf=%b lat=%0d want q=%h r=%h div0=%b ovf=%b lat=%0d",
                 name, i, v[i].a, v[i].b, QUOT, REM, DIV0, OVF, lat,
                 v[i].q, v[i].r, v[i].div0, v[i].ovf, want_lat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    logic held_ok = 1'b1;
    @(negedge CLK);
    DIVIDEND = 12'h3E8;
    DIVISOR  = 4'h7;
    START    = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (n == 3) begin
        START    = 1'b1;
        DIVIDEND = 12'h0FF;
        DIVISOR  = 4'h1;
      end
      if (n == 6) START = 1'b0;
      if (BUSY && (QUOT !== 8'h78 || REM !== 4'h0)) held_ok = 1'b0;
      if (DONE) begin
        lat = n;
        break;
      end
    end
    START = 1'b0;
    checks++;
    if (!held_ok) begin errors++; $display("FAIL ignore_hold_during_run got changed want q=78 r=0"); end
    checks++;
    if (lat !== 9 || QUOT !== 8'h8E || REM !== 4'h6) begin
      errors++;
      $display("FAIL ignore_start got lat=%0d q=%h r=%h want lat=9 q=8e r=6", lat, QUOT, REM);
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    logic [11:0] r1 = 12'h0;
    @(negedge CLK);
    DIVIDEND = 12'h4B0;
    DIVISOR  = 4'hA;
    START    = 1'b1;
    @(posedge CLK);
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (DONE) begin
        if (d1 < 0) begin
          d1 = n;
          r1 = {QUOT, REM};
          DIVIDEND = 12'h0FF;
          DIVISOR  = 4'h1;
        end else begin
          d2 = n;
          break;
        end
      end
    end
    START = 1'b0;
    checks++;
    if (d1 !== 9 || r1 !== 12'h780) begin
      errors++;
      $display("FAIL b2b_first got at=%0d q_r=%h want at=9 q_r=780", d1, r1);
    end
    checks++;
    if (d2 - d1 !== 10 || QUOT !== 8'hFF || REM !== 4'h0) begin
      errors++;
      $display("FAIL b2b_second got gap=%0d q=%h r=%h want gap=10 q=ff r=0", d2 - d1, QUOT, REM);
    end
  endtask

  task automatic test_reset_mid();
    int lat, busy_n;
    int done_seen = 0;
    @(negedge CLK);
    DIVIDEND = 12'h4B0;
    DIVISOR  = 4'hA;
    START    = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, QUOT, REM, DIV0, OVF} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b q=%h r=%h div0=%b ovf=%b want all zero",
               BUSY, DONE, QUOT, REM, DIV0, OVF);
    end
    RST_N = 1'b1;
    repeat (15) begin
      @(negedge CLK);
      if (DONE) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d pulses want 0", done_seen); end
    run_op(12'h0FF, 4'h1, lat, busy_n);
    checks++;
    if (lat !== 9 || QUOT !== 8'hFF || REM !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_after got lat=%0d q=%h r=%h want lat=9 q=ff r=0", lat, QUOT, REM);
    end
  endtask

  task automatic test_sweep();
    int lat, busy_n;
    logic [11:0] a;
    logic [3:0]  b;
    logic [7:0]  eq;
    logic [3:0]  er;
    logic        ed, eo;
    int          el;
    for (int i = 0; i < 2000; i++) begin
      a = 12'($urandom_range(0, 4095));
      b = 4'($urandom_range(0, 15));
      ed = (b == 4'd0);
      eo = !ed && (a[11:8] >= b);
      if (ed || eo) begin
        eq = 8'hFF; er = 4'hF; el = 1;
      end else begin
        eq = 8'(a / b); er = 4'(a % b); el = 9;
      end
      run_op(a, b, lat, busy_n);
      checks++;
      if ({QUOT, REM, DIV0, OVF} !== {eq, er, ed, eo} || lat !== el) begin
        errors++;
        $display("FAIL sweep[%0d] %h/%h got q=%h r=%h div0=%b ovf=%b lat=%0d want q=%h r=%h div0=%b ovf=%b lat=%0d",
                 i, a, b, QUOT, REM, DIV0, OVF, lat, eq, er, ed, eo, el);
      end
    end
  endtask

  initial begin
    vec_t normal_v[] = '{
      '{12'hEFF, 4'hF, 8'hFF, 4'hE, 1'b0, 1'b0},
      '{12'h000, 4'h5, 8'h00, 4'h0, 1'b0, 1'b0},
      '{12'h0FF, 4'h1, 8'hFF, 4'h0, 1'b0, 1'b0},
      '{12'h0AB, 4'h1, 8'hAB, 4'h0, 1'b0, 1'b0},
      '{12'h0FF, 4'h2, 8'h7F, 4'h1, 1'b0, 1'b0},
      '{12'h7D3, 4'h9, 8'hDE, 4'h5, 1'b0, 1'b0},
      '{12'h5A5, 4'hC, 8'h78, 4'h5, 1'b0, 1'b0}
    };
    vec_t error_v[] = '{
      '{12'hF00, 4'hF, 8'hFF, 4'hF, 1'b0, 1'b1},
      '{12'h123, 4'h0, 8'hFF, 4'hF, 1'b1, 1'b0},
      '{12'h100, 4'h1, 8'hFF, 4'hF, 1'b0, 1'b1},
      '{12'h000, 4'h0, 8'hFF, 4'hF, 1'b1, 1'b0}
    };

    test_reset();
    test_basic();
    test_ignore_start();
    test_table("normal", normal_v);
    test_table("error", error_v);
    test_back_to_back();
    test_reset_mid();
    test_sweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
